// File: rtl/decoder_3x8_pulse.sv
// 3-to-8 one-hot decoder that drives each accepted code for HOLD_CYCLES clocks,
// then holds the output low for GAP_CYCLES clocks before taking the next code.
module decoder_3x8_pulse #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [2:0] code;
    logic [2:0] code_next;
    logic [7:0] y_next;
    logic       out_valid_next;
    logic       busy_next;
    logic       done_next;
    logic       transfer;

    assign in_ready = (state == IDLE) && en;
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            code      <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            code      <= code_next;
            y         <= y_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Dropping en abandons whatever is in flight and parks the block in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state_next = DRIVE;
                        cnt_next   = HOLD_LOAD;
                        code_next  = in_code;
                    end
                end
                DRIVE: begin
                    if (cnt != 8'd0) begin
                        cnt_next = cnt - 8'd1;
                    end else if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (cnt != 8'd0) begin
                        cnt_next = cnt - 8'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        y_next         = '0;
        out_valid_next = 1'b0;
        busy_next      = (state_next != IDLE);
        done_next      = en && (state == DRIVE) && (cnt == 8'd0);
        if (state_next == DRIVE) begin
            y_next         = 8'd1 << code_next;
            out_valid_next = 1'b1;
        end
    end

endmodule

// File: doc/decoder_3x8_pulse.md
DECODER_3X8_PULSE -- requirements
Module: decoder_3x8_pulse

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of clk cycles a decoded one-hot output is driven; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1: number of clk cycles of all-zero output after each hold before the next code is accepted; legal range 0..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  1  block enable; low aborts any activity and blocks acceptance.
REQ-006 in_valid  input  1  in_code is valid this cycle.
REQ-007 in_code  input  3  binary code 0..7 to decode.
REQ-008 in_ready  output  1  block accepts a code this cycle; combinational from state and en.
REQ-009 y  output  8  registered one-hot decoded output; y[n] high for code n, all-zero otherwise.
REQ-010 out_valid  output  1  registered; high exactly while y is non-zero.
REQ-011 busy  output  1  registered; high in DRIVE or GAP.
REQ-012 done  output  1  registered; one-cycle pulse marking completion of a hold.

Function
REQ-013 The FSM SHALL have three states: IDLE, DRIVE, GAP, plus an 8-bit down-counter cnt.
REQ-014 in_ready SHALL equal (state==IDLE) AND en.
REQ-015 A transfer SHALL occur on a rising edge where in_valid AND in_ready are both 1; no other edge accepts a code.
REQ-016 On a transfer the block SHALL capture in_code, go to DRIVE, and load cnt = HOLD_CYCLES-1.
REQ-017 Latency: y SHALL become one-hot (y = 1 << in_code) in the cycle immediately after the transfer edge.
REQ-018 In DRIVE, y SHALL remain constant for exactly HOLD_CYCLES cycles; in_code changes SHALL be ignored.
REQ-019 In DRIVE with cnt != 0, cnt SHALL decrement by 1 per cycle.
REQ-020 In DRIVE with cnt==0: if GAP_CYCLES==0 go to IDLE, else go to GAP and load cnt = GAP_CYCLES-1; y SHALL be all-zero from the next cycle.
REQ-021 done SHALL be 1 in the single cycle after the last DRIVE cycle, and 0 at all other times.
REQ-022 In GAP, y SHALL be all-zero, and cnt SHALL decrement each cycle; at cnt==0 the block SHALL go to IDLE.
REQ-023 Back-to-back: with GAP_CYCLES==0 and in_valid held high, a new code SHALL be accepted on the edge ending the first IDLE cycle, so one zero-output cycle separates consecutive holds.
REQ-024 en low in DRIVE or GAP SHALL force the next state to IDLE with y=0, out_valid=0, busy=0, and done SHALL NOT pulse.
REQ-025 If en falls in the same cycle as the last DRIVE cycle, abort (REQ-024) SHALL take priority and done SHALL stay 0.
REQ-026 in_valid while busy SHALL have no effect; the code is neither queued nor dropped with an error, and the source must hold it until in_ready.
REQ-027 In IDLE, y SHALL be 0 and out_valid, busy, done SHALL be 0.
REQ-028 Every one of the 8 codes SHALL produce exactly one high bit in y; y SHALL never carry more than one high bit.

Reset
REQ-029 rst high at a rising edge SHALL force state=IDLE, cnt=0, y=8'h00, out_valid=0, busy=0, done=0 at the next cycle, regardless of the current state.
REQ-030 rst SHALL take priority over en and over a transfer in the same cycle, and the captured code SHALL be discarded.
REQ-031 Reset asserted mid-DRIVE SHALL clear y in the next cycle without a done pulse.

Verification
REQ-032 Sweep: defaults, en=1, codes 0..7 each offered once -> y = 01,02,04,...,80, each held for 4 cycles, each followed by a 1-cycle done pulse and a 1-cycle gap.
REQ-033 Latency/hold: transfer of code 5 at edge k -> y=8'h20 during cycles k+1..k+4, done=1 at cycle k+5, in_ready=1 again at cycle k+6.
REQ-034 Abort: code 3 accepted, en dropped during the 2nd DRIVE cycle -> y=0 and busy=0 in the next cycle, no done pulse, in_ready=0 until en returns.
REQ-035 Reset mid-operation: rst pulsed during DRIVE of code 7 -> all outputs 0 at the next cycle; the next offered code 1 gives y=8'h02 normally.
REQ-036 Busy blocking: in_valid held high with changing in_code during DRIVE -> y unchanged, in_ready=0; the code present at the next IDLE cycle is the one accepted.
REQ-037 Edge parameters: HOLD_CYCLES=1, GAP_CYCLES=0 with in_valid held high -> alternating one-hot cycle / zero cycle, a done pulse after each hold, and y never multi-hot.
